// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module : multdiv_pkg
// Brief  : Shared constants for the multdiv unit (divider state encoding, sizes)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division iteration (shift, trial subtract)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] dvdNext,
  output logic             qBit
);

  logic [WIDTH-1:0] w_remShift;
  logic [WIDTH:0]   w_trial;
  logic             w_unusedRemMsb;

  // rem always stays below divisor <= 2^(WIDTH-1), so its MSB is never set
  assign w_unusedRemMsb = rem[WIDTH-1];

  assign w_remShift = {rem[WIDTH-2:0], dvd[WIDTH-1]};
  assign w_trial    = {1'b0, w_remShift} - {1'b0, divisor};
  assign qBit       = ~w_trial[WIDTH];
  assign remNext    = qBit ? w_trial[WIDTH-1:0] : w_remShift;
  assign dvdNext    = {dvd[WIDTH-2:0], qBit};

endmodule

`default_nettype wire

// File: rtl/div_controller.sv
// ============================================================================
// Module : div_controller
// Brief  : Sequencer for the signed iterative restoring divider
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_controller
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_divisor;
  logic             r_qNeg;
  logic             r_rNeg;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remOut;
  logic             r_exc;
  logic             r_rdy;

  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_dvdNext;
  logic             w_qBit;

  // Negating INT_MIN yields 0x80...0, which is the correct unsigned magnitude
  assign w_absA = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign w_absB = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (r_rem),
    .dvd     (r_dvd),
    .divisor (r_divisor),
    .remNext (w_remNext),
    .dvdNext (w_dvdNext),
    .qBit    (w_qBit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_divisor <= '0;
      r_qNeg    <= 1'b0;
      r_rNeg    <= 1'b0;
      r_result  <= '0;
      r_remOut  <= '0;
      r_exc     <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (ctrl_DIV) begin
            r_dvd     <= w_absA;
            r_rem     <= '0;
            r_divisor <= w_absB;
            r_qNeg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_rNeg    <= data_operandA[WIDTH-1];
            r_cnt     <= '0;
            if (data_operandB == '0) begin
              r_state  <= DONE;
              r_result <= '0;
              r_remOut <= '0;
              r_exc    <= 1'b1;
              r_rdy    <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_rem <= w_remNext;
          r_dvd <= w_dvdNext;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST_CNT) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result <= r_qNeg ? (~r_dvd + 1'b1) : r_dvd;
          r_remOut <= r_rNeg ? (~r_rem + 1'b1) : r_rem;
          r_exc    <= 1'b0;
          r_rdy    <= 1'b1;
          r_state  <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_remainder = r_remOut;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state == RUN) || (r_state == FIX);

endmodule

`default_nettype wire
